// File: rtl/core_pkg.sv
// core_pkg: shared FSM state encoding and defaults for core_ctrl.
// Imported by core_ctrl.
package core_pkg;

  typedef enum logic [2:0] {
    FETCH_REQ,
    FETCH_WAIT,
    EXEC,
    WB,
    HALT
  } state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam int          CNT_W_DEF    = 64;

endpackage

// File: rtl/core_ctrl.sv
// core_ctrl: multi-cycle fetch/exec/writeback sequencer for a single-issue core.
// Optional DIFFTEST_EN adds the commit_valid/commit_pc trace port.
module core_ctrl
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifetch_req_valid,
  input  logic             ifetch_req_ready,
  output logic [31:0]      ifetch_addr,
  input  logic             ifetch_rsp_valid,
  input  logic [31:0]      ifetch_rsp_data,
  output logic [31:0]      inst_ex,
  output logic [31:0]      pc_ex,
  input  logic [31:0]      dnpc,
  input  logic             reg_wen_ex,
  input  logic             ebreak,
  output logic             reg_wen_commit,
  output logic             halt,
  output logic             trap_misalign,
`ifdef DIFFTEST_EN
  output logic             commit_valid,
  output logic [31:0]      commit_pc,
`endif
  output logic [CNT_W-1:0] inst_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  state_t state_nxt;
  logic   aligned;

  assign aligned = (dnpc[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH_REQ;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH_REQ:
        if (ifetch_req_ready) state_nxt = FETCH_WAIT;
      FETCH_WAIT:
        if (ifetch_rsp_valid) state_nxt = EXEC;
      EXEC:
        state_nxt = WB;
      WB:
        if (!aligned || ebreak) state_nxt = HALT;
        else                    state_nxt = FETCH_REQ;
      HALT:
        state_nxt = HALT;
      default:
        state_nxt = FETCH_REQ;
    endcase
  end

  // Outputs are masked while rst is high so a reset held over
  // several cycles never issues a fetch or a write strobe.
  always_comb begin
    ifetch_req_valid = !rst && (state == FETCH_REQ);
    reg_wen_commit   = !rst && (state == WB) && aligned
                       && reg_wen_ex;
    halt             = !rst && (state == HALT);
    ifetch_addr      = pc_ex;
`ifdef DIFFTEST_EN
    commit_valid     = !rst && (state == WB) && aligned;
    commit_pc        = pc_ex;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_ex         <= RESET_PC;
      inst_ex       <= 32'h0;
      inst_cnt      <= '0;
      trap_misalign <= 1'b0;
    end else begin
      if (state == FETCH_WAIT && ifetch_rsp_valid)
        inst_ex <= ifetch_rsp_data;
      if (state == WB) begin
        if (aligned) begin
          inst_cnt <= inst_cnt + CNT_ONE;
          if (!ebreak) pc_ex <= dnpc;
        end else begin
          trap_misalign <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: directed scoreboard bench for core_ctrl.
// Fetch addresses and commit strobes are checked by a negedge monitor.
module tb_core_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifetch_req_valid;
  logic        ifetch_req_ready = 1'b0;
  logic [31:0] ifetch_addr;
  logic        ifetch_rsp_valid = 1'b0;
  logic [31:0] ifetch_rsp_data = 32'h0;
  logic [31:0] inst_ex;
  logic [31:0] pc_ex;
  logic [31:0] dnpc = 32'h0;
  logic        reg_wen_ex = 1'b0;
  logic        ebreak = 1'b0;
  logic        reg_wen_commit;
  logic        halt;
  logic        trap_misalign;
  logic [63:0] inst_cnt;
`ifdef DIFFTEST_EN
  logic        commit_valid;
  logic [31:0] commit_pc;
`endif

  core_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .ifetch_req_valid (ifetch_req_valid),
    .ifetch_req_ready (ifetch_req_ready),
    .ifetch_addr      (ifetch_addr),
    .ifetch_rsp_valid (ifetch_rsp_valid),
    .ifetch_rsp_data  (ifetch_rsp_data),
    .inst_ex          (inst_ex),
    .pc_ex            (pc_ex),
    .dnpc             (dnpc),
    .reg_wen_ex       (reg_wen_ex),
    .ebreak           (ebreak),
    .reg_wen_commit   (reg_wen_commit),
    .halt             (halt),
    .trap_misalign    (trap_misalign),
`ifdef DIFFTEST_EN
    .commit_valid     (commit_valid),
    .commit_pc        (commit_pc),
`endif
    .inst_cnt         (inst_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_wen[$];
  logic [31:0] exp_cpc[$];

  logic [31:0] m_pc;
  logic [63:0] m_cnt;
  logic        m_halt;
  logic        m_trap;

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  logic prev_wen = 1'b0;
  always @(negedge clk) begin
    if (ifetch_req_valid && ifetch_req_ready) begin
      if (exp_addr.size() == 0) check("fetch_unexpected", 1, 0);
      else check("fetch_addr", ifetch_addr, exp_addr.pop_front());
    end
    if (reg_wen_commit) begin
      if (prev_wen) check("strobe_width", 2, 1);
      else if (exp_wen.size() == 0) check("strobe_unexpected", 1, 0);
      else check("strobe_pc", pc_ex, exp_wen.pop_front());
    end
    prev_wen = reg_wen_commit;
`ifdef DIFFTEST_EN
    if (commit_valid) begin
      if (exp_cpc.size() == 0) check("commit_unexpected", 1, 0);
      else check("commit_pc", commit_pc, exp_cpc.pop_front());
    end
`endif
  end

  task automatic model_reset();
    m_pc = 32'h8000_0000;
    m_cnt = 64'h0;
    m_halt = 1'b0;
    m_trap = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_pc"}, pc_ex, m_pc);
    check({tag, "_cnt"}, inst_cnt, m_cnt);
    check({tag, "_halt"}, halt, m_halt);
    check({tag, "_trap"}, trap_misalign, m_trap);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_req_valid", ifetch_req_valid, 0);
    check("rst_wen", reg_wen_commit, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    model_reset();
    check("rst_inst_ex", inst_ex, 0);
    check("rst_valid_after", ifetch_req_valid, 1);
    check_state("rst");
  endtask

  task automatic run_inst(input int rd, input int sd,
                          input logic [31:0] inst,
                          input logic [31:0] np,
                          input logic wen, input logic eb,
                          input logic exec_wen, input logic junk,
                          output int lat);
    int c0, vcnt, n;
    logic stable, hold;
    logic [31:0] prev;
    lat = 0;
    dnpc = np;
    ebreak = eb;
    reg_wen_ex = 1'b0;
    n = 0;
    while (!ifetch_req_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ifetch_req_valid) begin
      check("req_valid_timeout", 0, 1);
      return;
    end
    c0 = cyc;
    prev = inst_ex;
    vcnt = 0;
    stable = 1'b1;
    hold = 1'b1;
    exp_addr.push_back(m_pc);
    for (int i = 0; i < rd; i++) begin
      if (ifetch_req_valid) vcnt++;
      if (ifetch_addr !== m_pc) stable = 1'b0;
      ifetch_rsp_valid = junk;
      ifetch_rsp_data = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      if (inst_ex !== prev) hold = 1'b0;
    end
    if (ifetch_req_valid) vcnt++;
    if (ifetch_addr !== m_pc) stable = 1'b0;
    ifetch_rsp_valid = 1'b0;
    ifetch_req_ready = 1'b1;
    @(posedge clk); #1;
    ifetch_req_ready = 1'b0;
    for (int i = 1; i < sd; i++) begin
      @(posedge clk); #1;
      if (inst_ex !== prev) hold = 1'b0;
    end
    ifetch_rsp_valid = 1'b1;
    ifetch_rsp_data = inst;
    @(posedge clk); #1;
    ifetch_rsp_valid = 1'b0;
    check("inst_latch", inst_ex, inst);
    reg_wen_ex = exec_wen;
    @(posedge clk); #1;
    reg_wen_ex = wen;
    if (np[1:0] == 2'b00) begin
      if (wen) exp_wen.push_back(m_pc);
      exp_cpc.push_back(m_pc);
    end
    @(posedge clk); #1;
    reg_wen_ex = 1'b0;
    ebreak = 1'b0;
    lat = cyc - c0;
    if (np[1:0] != 2'b00) begin
      m_trap = 1'b1;
      m_halt = 1'b1;
    end else begin
      m_cnt++;
      if (eb) m_halt = 1'b1;
      else m_pc = np;
    end
    check("req_valid_cycles", vcnt, rd + 1);
    check("addr_stable", stable, 1);
    check("inst_hold", hold, 1);
  endtask

  task automatic check_quiet(input int cycles);
    int v = 0;
    int h = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (ifetch_req_valid) v++;
      if (halt) h++;
    end
    check("halt_no_fetch", v, 0);
    check("halt_sticky", h, cycles);
  endtask

  int lat;

  initial begin
    model_reset();
    reset_dut();

    // Minimum-latency instruction then a second fetch at pc+4.
    run_inst(0, 1, 32'h0000_0013, 32'h8000_0004, 1, 0, 0, 0, lat);
    check("lat_min", lat, 4);
    check_state("i1");
    check("i1_cnt_hand", inst_cnt, 1);

    // Stalled handshake with junk responses before acceptance.
    run_inst(3, 5, 32'h0010_0093, 32'h8000_0008, 0, 0, 0, 1, lat);
    check("lat_stall", lat, 11);
    check_state("i2");

    // Write request only in EXEC: no strobe may appear.
    run_inst(0, 1, 32'h0020_0113, 32'h8000_0010, 0, 0, 1, 0, lat);
    check_state("i3");
    check("i3_pc_hand", pc_ex, 32'h8000_0010);

    // ebreak at 0x8000_0010 commits and halts.
    run_inst(1, 2, 32'h0010_0073, 32'h8000_0014, 1, 1, 0, 0, lat);
    check_state("ebrk");
    check("ebrk_pc_hand", pc_ex, 32'h8000_0010);
    check("ebrk_cnt_hand", inst_cnt, 4);
    check_quiet(20);

    // Misaligned dnpc traps without committing.
    reset_dut();
    run_inst(0, 1, 32'h0000_0013, 32'h8000_0006, 1, 0, 0, 0, lat);
    check_state("mis");
    check("mis_cnt_hand", inst_cnt, 0);
    check_quiet(5);

    // Misalign beats ebreak.
    reset_dut();
    run_inst(0, 1, 32'h0010_0073, 32'h8000_0006, 1, 1, 0, 0, lat);
    check_state("mis_eb");
    check("mis_eb_trap_hand", trap_misalign, 1);
    check_quiet(5);

    // Reset in FETCH_WAIT, stale response two cycles later.
    reset_dut();
    ifetch_req_ready = 1'b1;
    exp_addr.push_back(32'h8000_0000);
    @(posedge clk); #1;
    ifetch_req_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid_valid", ifetch_req_valid, 1);
    check("mid_addr", ifetch_addr, 32'h8000_0000);
    @(posedge clk); #1;
    ifetch_rsp_valid = 1'b1;
    ifetch_rsp_data = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    ifetch_rsp_valid = 1'b0;
    check("stale_inst_ex", inst_ex, 0);
    check("stale_valid", ifetch_req_valid, 1);
    model_reset();
    run_inst(0, 1, 32'h0000_0013, 32'h8000_0004, 1, 0, 0, 0, lat);
    check_state("post_rst");
    check("post_rst_lat", lat, 4);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", exp_addr.size() + exp_wen.size(), 0);
`ifdef DIFFTEST_EN
    check("cpc_empty", exp_cpc.size(), 0);
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

endmodule
